// File: rtl/kbd_pkg.sv
// Shared definitions for the scripted key-injection sequencer: FSM states,
// well-known scancodes and ps2_key field positions.
package kbd_pkg;

    localparam int KEY_CODE_MSB = 7;
    localparam int KEY_EXT      = 8;
    localparam int KEY_PRESSED  = 9;
    localparam int KEY_TOGGLE   = 10;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_END    = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_WAIT     = 4'd2,
        ST_SHIFT_DN = 4'd3,
        ST_PRESS    = 4'd4,
        ST_HOLD     = 4'd5,
        ST_RELEASE  = 4'd6,
        ST_SHIFT_UP = 4'd7,
        ST_GAP      = 4'd8,
        ST_FINISH   = 4'd9
    } state_t;

    function automatic logic [9:0] key_evt(input logic pressed, input logic ext,
                                           input logic [7:0] code);
        return {pressed, ext, code};
    endfunction

endpackage

// File: rtl/kbd_autotype_if.sv
// Control and script-ROM bus of the auto-typer; master is the sequencer side.
interface kbd_autotype_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [9:0]        rom_data;

    modport master (input start, input rom_data, output busy, output done, output rom_addr);
    modport slave  (output start, output rom_data, input busy, input done, input rom_addr);
endinterface

// File: rtl/kbd_autotype_merge.sv
// Merges injected and live ps2_key events onto one toggle-coded bus;
// injected events win, a colliding live event waits one cycle in a 1-entry slot.
module ps2_evt_merge
    import kbd_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key_in,
    input  logic        inject_valid,
    input  logic [9:0]  inject_data,
    output logic        inject_ready,
    output logic        live_evt,
    output logic [10:0] ps2_key_out
);

    logic       armed;
    logic       live_tog;
    logic       pending;
    logic [9:0] pend_data;

    // armed keeps the first post-reset sample from looking like a key event
    assign live_evt     = armed && (ps2_key_in[KEY_TOGGLE] != live_tog);
    assign inject_ready = !pending;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            armed       <= 1'b0;
            live_tog    <= 1'b0;
            pending     <= 1'b0;
            pend_data   <= '0;
            ps2_key_out <= '0;
        end else begin
            armed    <= 1'b1;
            live_tog <= ps2_key_in[KEY_TOGGLE];
            if (pending) begin
                ps2_key_out <= {~ps2_key_out[KEY_TOGGLE], pend_data};
                pending     <= live_evt;
                if (live_evt)
                    pend_data <= ps2_key_in[9:0];
            end else if (inject_valid) begin
                ps2_key_out <= {~ps2_key_out[KEY_TOGGLE], inject_data};
                if (live_evt) begin
                    pending   <= 1'b1;
                    pend_data <= ps2_key_in[9:0];
                end
            end else if (live_evt) begin
                ps2_key_out <= {~ps2_key_out[KEY_TOGGLE], ps2_key_in[9:0]};
            end
        end
    end

endmodule

// File: rtl/kbd_autotype.sv
// Scripted key injector: walks a ROM key script, emitting timed press/release
// events (with optional left-shift wrap) merged with the live keyboard stream.
module kbd_autotype
    import kbd_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 400000,
    parameter int GAP_CYCLES  = 400000,
    parameter int CNT_W       = 20
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [10:0]        ps2_key_in,
    output logic [10:0]        ps2_key_out,
    kbd_autotype_if.master     bus
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rom_addr;
    logic              busy;
    logic              done;
    logic [7:0]        code_q;
    logic              ext_q;
    logic              shift_q;
    logic              abort_q;

    logic              inject_valid;
    logic              inject_ready;
    logic [9:0]        inject_data;
    logic              live_evt;
    logic              fire;
    logic              abort_det;
    logic              abort_now;

    assign bus.rom_addr = rom_addr;
    assign bus.busy     = busy;
    assign bus.done     = done;

    assign fire      = inject_valid && inject_ready;
    assign abort_det = busy && live_evt && ps2_key_in[KEY_PRESSED] &&
                       (ps2_key_in[KEY_CODE_MSB:0] == SC_ESC);
    assign abort_now = abort_det || abort_q;

    always_comb begin
        inject_valid = 1'b0;
        inject_data  = '0;
        case (state)
            ST_SHIFT_DN: begin inject_valid = 1'b1; inject_data = key_evt(1'b1, 1'b0, SC_LSHIFT); end
            ST_PRESS:    begin inject_valid = 1'b1; inject_data = key_evt(1'b1, ext_q, code_q);   end
            ST_RELEASE:  begin inject_valid = 1'b1; inject_data = key_evt(1'b0, ext_q, code_q);   end
            ST_SHIFT_UP: begin inject_valid = 1'b1; inject_data = key_evt(1'b0, 1'b0, SC_LSHIFT); end
            default: ;
        endcase
    end

    // Timers leave on the count of 1 so the press-to-release distance equals
    // HOLD_CYCLES including the cycle spent in RELEASE.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            code_q   <= '0;
            ext_q    <= 1'b0;
            shift_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_det)
                abort_q <= 1'b1;
            case (state)
                ST_IDLE: if (bus.start) begin
                    rom_addr <= '0;
                    busy     <= 1'b1;
                    abort_q  <= 1'b0;
                    state    <= ST_FETCH;
                end
                ST_FETCH: state <= abort_now ? ST_FINISH : ST_WAIT;
                ST_WAIT: begin
                    code_q  <= bus.rom_data[7:0];
                    ext_q   <= bus.rom_data[8];
                    shift_q <= bus.rom_data[9];
                    if (abort_now || bus.rom_data[7:0] == SC_END)
                        state <= ST_FINISH;
                    else if (bus.rom_data[9])
                        state <= ST_SHIFT_DN;
                    else
                        state <= ST_PRESS;
                end
                ST_SHIFT_DN: begin
                    if (fire)
                        state <= abort_now ? ST_SHIFT_UP : ST_PRESS;
                    else if (abort_now)
                        state <= ST_FINISH;
                end
                ST_PRESS: begin
                    if (fire) begin
                        if (abort_now) begin
                            state <= ST_RELEASE;
                        end else begin
                            cnt   <= CNT_W'(HOLD_CYCLES - 1);
                            state <= ST_HOLD;
                        end
                    end else if (abort_now) begin
                        state <= shift_q ? ST_SHIFT_UP : ST_FINISH;
                    end
                end
                ST_HOLD: begin
                    if (abort_now || cnt <= CNT_W'(1))
                        state <= ST_RELEASE;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_RELEASE: if (fire) begin
                    if (shift_q) begin
                        state <= ST_SHIFT_UP;
                    end else if (abort_now) begin
                        state <= ST_FINISH;
                    end else begin
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                        state <= ST_GAP;
                    end
                end
                ST_SHIFT_UP: if (fire) begin
                    if (abort_now) begin
                        state <= ST_FINISH;
                    end else begin
                        cnt   <= CNT_W'(GAP_CYCLES - 1);
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (abort_now) begin
                        state <= ST_FINISH;
                    end else if (cnt <= CNT_W'(1)) begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= (rom_addr == '1) ? ST_FINISH : ST_FETCH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    abort_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ps2_evt_merge u_merge (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_key_in   (ps2_key_in),
        .inject_valid (inject_valid),
        .inject_data  (inject_data),
        .inject_ready (inject_ready),
        .live_evt     (live_evt),
        .ps2_key_out  (ps2_key_out)
    );

endmodule

// File: tb/tb_kbd_autotype.sv
// Directed bench for kbd_autotype: script playback, shift wrap, live merge,
// Esc abort, reset mid-script and address wrap on a 4-entry script.
module tb_kbd_autotype;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b0;
    logic [10:0] key_in  = '0;
    logic [10:0] key_in2 = '0;
    logic [10:0] key_out;
    logic [10:0] key_out2;

    kbd_autotype_if #(.ADDR_W(8)) bus1 ();
    kbd_autotype_if #(.ADDR_W(2)) bus2 ();

    kbd_autotype #(.ADDR_W(8), .HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_W(20)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key_in(key_in),
        .ps2_key_out(key_out), .bus(bus1)
    );
    kbd_autotype #(.ADDR_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_W(20)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .ps2_key_in(key_in2),
        .ps2_key_out(key_out2), .bus(bus2)
    );

    always #5 clk_sys = ~clk_sys;

    logic [9:0] rom1 [0:255];
    logic [9:0] rom2 [0:3];
    always @(posedge clk_sys) begin
        bus1.rom_data <= rom1[bus1.rom_addr];
        bus2.rom_data <= rom2[bus2.rom_addr];
    end

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    logic       prev1 = 1'b0, prev2 = 1'b0;
    logic [9:0] ev1 [$];
    logic [9:0] ev2 [$];
    int         evc1 [$];
    int         dn1 = 0, dn2 = 0;
    always @(posedge clk_sys) begin
        #1;
        if (reset) begin
            prev1 = key_out[10];
            prev2 = key_out2[10];
        end else begin
            if (key_out[10] !== prev1) begin
                ev1.push_back(key_out[9:0]);
                evc1.push_back(cyc);
                prev1 = key_out[10];
            end
            if (key_out2[10] !== prev2) begin
                ev2.push_back(key_out2[9:0]);
                prev2 = key_out2[10];
            end
            if (bus1.done === 1'b1) dn1++;
            if (bus2.done === 1'b1) dn2++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [9:0] ev_at(input int i);
        return (i < ev1.size()) ? ev1[i] : 10'h3FF;
    endfunction

    function automatic int gap_at(input int i);
        return (i + 1 < evc1.size()) ? evc1[i+1] - evc1[i] : -1;
    endfunction

    task automatic clear1();
        ev1.delete();
        evc1.delete();
        dn1 = 0;
    endtask

    task automatic start1();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
    endtask

    task automatic wait_done1(input string tag);
        for (int i = 0; i < 400 && dn1 == 0; i++) tick();
        tick();
        tick();
        check({tag, "_done_pulses"}, dn1, 1);
        check({tag, "_busy_after"}, bus1.busy, 1'b0);
    endtask

    logic [9:0] exp_run [8];
    logic       t;

    initial begin
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        for (int i = 0; i < 256; i++) rom1[i] = '0;
        for (int i = 0; i < 4; i++) rom2[i] = 10'h016;

        #2 reset = 1'b1;
        #1;
        check("rst_key_out", key_out, 11'h000);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_done", bus1.done, 1'b0);
        check("rst_rom_addr", bus1.rom_addr, 8'h00);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // "RUN" + Enter
        rom1[0] = 10'h02D; rom1[1] = 10'h03C; rom1[2] = 10'h031;
        rom1[3] = 10'h05A; rom1[4] = 10'h000;
        exp_run = '{10'h22D, 10'h02D, 10'h23C, 10'h03C, 10'h231, 10'h031, 10'h25A, 10'h05A};
        clear1();
        start1();
        wait_done1("run");
        check("run_count", ev1.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("run_ev%0d", i), ev_at(i), exp_run[i]);
        check("run_hold_R", gap_at(0), 4);
        check("run_hold_Enter", gap_at(6), 4);
        check("run_done_low", bus1.done, 1'b0);

        // live forwarding while idle, 1-cycle latency
        t = key_out[10];
        key_in = {1'b1, 10'h21B};
        tick();
        check("live_press", key_out, {~t, 10'h21B});
        key_in = {1'b0, 10'h01B};
        tick();
        check("live_release", key_out, {t, 10'h01B});
        tick();

        // shifted key
        rom1[0] = 10'h21C; rom1[1] = 10'h000;
        clear1();
        start1();
        wait_done1("shift");
        check("shift_count", ev1.size(), 4);
        check("shift_ev0", ev_at(0), 10'h212);
        check("shift_ev1", ev_at(1), 10'h21C);
        check("shift_ev2", ev_at(2), 10'h01C);
        check("shift_ev3", ev_at(3), 10'h012);

        // live event colliding with injected press
        rom1[0] = 10'h01C; rom1[1] = 10'h000;
        clear1();
        start1();
        tick();
        tick();
        key_in = {~key_in[10], 10'h22B};
        wait_done1("coll");
        check("coll_count", ev1.size(), 3);
        check("coll_ev0", ev_at(0), 10'h21C);
        check("coll_ev1", ev_at(1), 10'h22B);
        check("coll_ev2", ev_at(2), 10'h01C);
        check("coll_spacing", gap_at(0), 1);
        key_in = {~key_in[10], 10'h02B};
        tick(); tick();

        // Esc abort during HOLD
        rom1[0] = 10'h01C; rom1[1] = 10'h02D; rom1[2] = 10'h000;
        clear1();
        start1();
        tick(); tick(); tick();
        key_in = {~key_in[10], 10'h276};
        wait_done1("esc");
        check("esc_count", ev1.size(), 3);
        check("esc_ev0", ev_at(0), 10'h21C);
        check("esc_ev1", ev_at(1), 10'h276);
        check("esc_ev2", ev_at(2), 10'h01C);
        check("esc_rom_addr", bus1.rom_addr, 8'h00);
        key_in = {~key_in[10], 10'h076};
        tick(); tick();

        // reset while in GAP after the second key
        rom1[0] = 10'h02D; rom1[1] = 10'h03C; rom1[2] = 10'h000;
        clear1();
        start1();
        for (int i = 0; i < 200 && ev1.size() < 4; i++) tick();
        check("rstgap_events", ev1.size(), 4);
        check("rstgap_addr_before", bus1.rom_addr, 8'h01);
        reset = 1'b1;
        #1;
        check("rstgap_key_out", key_out, 11'h000);
        check("rstgap_busy", bus1.busy, 1'b0);
        check("rstgap_done", bus1.done, 1'b0);
        check("rstgap_rom_addr", bus1.rom_addr, 8'h00);
        tick(); tick();
        reset = 1'b0;
        clear1();
        for (int i = 0; i < 30; i++) tick();
        check("rstgap_no_events", ev1.size(), 0);
        check("rstgap_no_done", dn1, 0);
        check("rstgap_idle_busy", bus1.busy, 1'b0);

        // 4-entry script without terminator ends on address wrap
        ev2.delete();
        dn2 = 0;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < 600 && dn2 == 0; i++) tick();
        tick(); tick();
        check("wrap_done_pulses", dn2, 1);
        check("wrap_count", ev2.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("wrap_ev%0d", i), (i < ev2.size()) ? ev2[i] : 10'h3FF,
                  (i % 2 == 0) ? 10'h216 : 10'h016);
        check("wrap_rom_addr", bus2.rom_addr, 2'd0);
        check("wrap_busy", bus2.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_autotype.md
Name: kbd_autotype

Overview:
- Scripted key-injection sequencer that shares the PS/2 key-event bus with the live keyboard.
- Reads a key script from a synchronous ROM and emits timed press/release events in the same 11-bit ps2_key format that the keyboard matrix decoder consumes.
- Merges injected events with live events onto one output bus.
- Sits between hps_io ps2_key and the keyboard matrix block; used for auto-typing loader commands (e.g. "RUN"+Enter).

Parameters:
- ADDR_W, 8: ROM address width; maximum script length is 2^ADDR_W entries.
- HOLD_CYCLES, 400000: cycles a key stays pressed (about 8 ms at 50 MHz).
- GAP_CYCLES, 400000: cycles between a release and the next press.
- CNT_W, 20: width of the hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk_sys in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- ps2_key_in in 11: live key event; [7:0] scancode, [8] extended, [9] pressed, [10] toggle.
- start in 1: one-cycle pulse that begins the script at address 0.
- rom_addr out ADDR_W: script ROM address.
- rom_data in 10: ROM word, 1-cycle read latency; [7:0] code, [8] extended, [9] needs shift. Code 8'h00 terminates the script.
- ps2_key_out out 11: merged event bus, same format as ps2_key_in.
- busy out 1: high while the script is running.
- done out 1: one-cycle pulse when the script ends or is aborted.

Behaviour:
- Reset values: ps2_key_out=0, rom_addr=0, busy=0, done=0, state=IDLE, pending=0. The live toggle tracker loads ps2_key_in[10] on the first clock after reset, so no spurious event is generated.
- Event emission: to emit an event, load [9:0] and invert ps2_key_out[10]. At most one emission per cycle.
- Live event detection: a change in ps2_key_in[10] versus the tracked value.
  - If no injected emission is scheduled that cycle, forward it on the next cycle (1-cycle latency).
  - Otherwise store it in a 1-entry pending register and emit it the following cycle. Injected events have priority.
  - The pending register drains before any further injected emission; injection is stalled while pending=1.
- Live events are always forwarded, including during busy.
- FSM states:
  - IDLE: on start, set rom_addr=0, busy=1, go to FETCH. start while busy is ignored.
  - FETCH: present address, go to WAIT.
  - WAIT: latch rom_data. If code==0, go to FINISH. Else if [9]=1, go to SHIFT_DN; else go to PRESS.
  - SHIFT_DN: emit 0x12 pressed, go to PRESS.
  - PRESS: emit code pressed with the ext bit, load counter=HOLD_CYCLES-1, go to HOLD.
  - HOLD: decrement the counter; at 0 go to RELEASE.
  - RELEASE: emit code released.
    - If shifted, go to SHIFT_UP (emit 0x12 released).
    - Then load counter=GAP_CYCLES-1 and go to GAP.
  - GAP: at 0, increment rom_addr. If rom_addr was 2^ADDR_W-1 (wrap), go to FINISH; else go to FETCH.
  - FINISH: busy=0, done=1 for one cycle, go to IDLE.
- Abort: a live event with code 8'h76 (Esc), pressed, seen while busy.
  - If the script key is currently down (HOLD state), emit its release next; if shift is down, emit the 0x12 release after that.
  - Then go to FINISH; the rest of the script is skipped.
  - The Esc event itself is still forwarded.
- Reset mid-script: the FSM returns to IDLE immediately and no release events are sent. The downstream matrix reset clears its own keys.

Decomposition:
- Shared package kbd_pkg holds:
  - state enum for the FSM;
  - constants SC_LSHIFT=8'h12, SC_ESC=8'h76, SC_END=8'h00;
  - the ps2_key field index localparams.
- One sub-module, ps2_evt_merge: live-toggle tracking, pending register, and output toggle generation. It takes an inject_valid/inject_ready handshake from the FSM.

Test Plan (run with HOLD_CYCLES=4, GAP_CYCLES=3):
- ROM holds {0x2D, 0x3C, 0x31, 0x5A, 0x00}; pulse start. Expect exactly 8 toggles on ps2_key_out[10] in order R↓ R↑ U↓ U↑ N↓ N↑ Enter↓ Enter↑, press-to-release spacing of 4 cycles, then done pulse, busy=0.
- ROM word 0x21C (shifted 0x1C). Expect 0x12↓, 0x1C↓, 0x1C↑, 0x12↑, then done.
- Live toggle arrives in the same cycle as an injected PRESS. Expect the injected event first, the live event exactly one cycle later, and no event lost (toggle count +2).
- Live Esc press during HOLD of 0x1C. Expect forwarded Esc↓, then 0x1C↑, then done; rom_addr does not advance further.
- Assert reset during GAP. Expect all outputs at their reset values immediately (asynchronous), busy=0, and no toggle after release.
- ADDR_W=2 with ROM full of 0x16 (no terminator). Expect 4 press/release pairs, then done on wrap.
